// File: rtl/aes_spi_pkg.sv
`default_nettype none
// ============================================================================
// Package  : aes_spi_pkg
// Purpose  : Shared sizes, FSM state encoding and key-length helper for the
//            SPI-side AES initiator.
// Revision : 1.0
// ============================================================================
package aes_spi_pkg;

    localparam int BLOCK_BITS = 128;
    localparam int WORD_BITS  = 32;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SEND_MSG = 3'd1;
    localparam logic [2:0] ST_SEND_KEY = 3'd2;
    localparam logic [2:0] ST_WAIT     = 3'd3;
    localparam logic [2:0] ST_RECV     = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    function automatic int KEY_BITS(input int nk);
        return nk * WORD_BITS;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_tx_shifter.sv
`default_nettype none
// ============================================================================
// Module   : spi_tx_shifter
// Purpose  : Parallel-in serial-out register; loads {key,msg} and shifts right
//            one bit per enable, presenting bit 0 as the serial output.
// Revision : 1.0
// ============================================================================
module spi_tx_shifter #(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_sout
);

    logic [WIDTH-1:0] r_data;

    // Zeros shift in from the top, so the line idles low once the frame is out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end else if (i_shift) begin
            r_data <= {1'b0, r_data[WIDTH-1:1]};
        end
    end

    assign o_sout = r_data[0];

endmodule
`default_nettype wire

// File: rtl/spi_aes_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_aes_master
// Purpose  : SPI-side initiator for the AES slave: sends block then key LSB-first
//            on SIMO, waits a fixed delay, then collects the 128-bit result from SOMI.
// Revision : 1.0
// ============================================================================
module spi_aes_master
    import aes_spi_pkg::*;
#(
    parameter int NK       = 4,
    parameter int NR       = 10,
    parameter int RX_DELAY = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    mode_in,
    input  logic [BLOCK_BITS-1:0]   msg,
    input  logic [NK*WORD_BITS-1:0] key,
    input  logic                    SOMI,
    output logic                    SIMO,
    output logic                    mode,
    output logic [BLOCK_BITS-1:0]   result,
    output logic                    busy,
    output logic                    done
);

    localparam int c_KEY_BITS = KEY_BITS(NK);
    localparam int c_TX_MAX   = (c_KEY_BITS > BLOCK_BITS) ? c_KEY_BITS : BLOCK_BITS;
    localparam int c_CNT_W_TX = $clog2(c_TX_MAX);
    localparam int c_CNT_W_RX = (RX_DELAY > 1) ? $clog2(RX_DELAY) : 1;
    localparam int c_CNT_W    = (c_CNT_W_TX > c_CNT_W_RX) ? c_CNT_W_TX : c_CNT_W_RX;

    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_BLK_LAST = c_CNT_W'(BLOCK_BITS - 1);
    localparam logic [c_CNT_W-1:0] c_KEY_LAST = c_CNT_W'(c_KEY_BITS - 1);
    localparam logic [c_CNT_W-1:0] c_DLY_LAST = c_CNT_W'(RX_DELAY - 1);

    if (!(NK == 4 || NK == 6 || NK == 8) || NR != NK + 6 || RX_DELAY < 1) begin : g_bad_cfg
        $error("spi_aes_master: unsupported NK/NR/RX_DELAY combination");
    end

    logic [2:0]            r_state;
    logic [2:0]            w_next;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [BLOCK_BITS-1:0] r_rx;
    logic                  w_load;
    logic                  w_shift;
    logic                  w_count;

    // The done cycle is still IDLE; masking start there forces a one-cycle gap.
    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_shift = 1'b0;
        w_count = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !done) begin
                    w_load = 1'b1;
                    w_next = ST_SEND_MSG;
                end
            end
            ST_SEND_MSG: begin
                w_shift = 1'b1;
                w_count = 1'b1;
                if (r_cnt == c_BLK_LAST) w_next = ST_SEND_KEY;
            end
            ST_SEND_KEY: begin
                w_shift = 1'b1;
                w_count = 1'b1;
                if (r_cnt == c_KEY_LAST) w_next = ST_WAIT;
            end
            ST_WAIT: begin
                w_shift = 1'b1;
                w_count = 1'b1;
                if (r_cnt == c_DLY_LAST) w_next = ST_RECV;
            end
            ST_RECV: begin
                w_count = 1'b1;
                if (r_cnt == c_BLK_LAST) w_next = ST_DONE;
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Message bit 0 goes out on the accept edge, so the message phase counts from 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_load) begin
            r_cnt <= c_CNT_ONE;
        end else if (w_next != r_state) begin
            r_cnt <= '0;
        end else if (w_count) begin
            r_cnt <= r_cnt + c_CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            r_rx   <= '0;
        end else begin
            done <= 1'b0;
            if (w_load) begin
                mode <= mode_in;
                busy <= 1'b1;
            end
            if (r_state == ST_RECV) begin
                r_rx <= {SOMI, r_rx[BLOCK_BITS-1:1]};
            end
            if (r_state == ST_DONE) begin
                result <= r_rx;
                done   <= 1'b1;
                busy   <= 1'b0;
            end
        end
    end

    spi_tx_shifter #(
        .WIDTH (BLOCK_BITS + c_KEY_BITS)
    ) u_tx (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  ({key, msg}),
        .o_sout  (SIMO)
    );

endmodule
`default_nettype wire

// File: tb/tb_spi_aes_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_aes_master
// Purpose  : Scoreboard bench for spi_aes_master (NK=4 and NK=8 instances) with
//            a behavioural SPI slave model on each.
// Revision : 1.0
// ============================================================================
module tb_spi_aes_master;

    localparam int RXD = 16;
    localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

    typedef struct packed {
        logic [127:0] m;
        logic [255:0] k;
        logic         md;
        logic [127:0] exp;
    } txn_t;

    logic         clk;
    logic         reset;
    logic         start_d  [2];
    logic         mode_d   [2];
    logic [127:0] msg_d    [2];
    logic [255:0] key_d    [2];
    logic         simo_v   [2];
    logic         mode_v   [2];
    logic [127:0] result_v [2];
    logic         busy_v   [2];
    logic         done_v   [2];

    int   cyc;
    int   n_tests;
    int   n_fail;
    txn_t q0[$];
    txn_t q1[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Stand-in for the slave core: the FIPS-197 vector, otherwise a keyed inversion.
    function automatic logic [127:0] ref_fn(input logic [127:0] m, input logic [255:0] k,
                                            input logic md);
        if (m == FIPS_PT && k == {128'h0, FIPS_KEY} && !md) return FIPS_CT;
        return ~m ^ k[127:0] ^ k[255:128] ^ {128{md}};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int q_size(input int idx);
        return (idx == 0) ? q0.size() : q1.size();
    endfunction

    function automatic txn_t q_front(input int idx);
        return (idx == 0) ? q0[0] : q1[0];
    endfunction

    function automatic txn_t q_pop(input int idx);
        if (idx == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic void q_push(input int idx, input txn_t t);
        if (idx == 0) q0.push_back(t);
        else q1.push_back(t);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int GNK = (g == 0) ? 4 : 8;
        localparam int GKB = GNK * 32;

        logic         somi;
        int           acc_cyc;
        logic [127:0] r_last;
        bit           chk_w;

        spi_aes_master #(
            .NK       (GNK),
            .NR       (GNK + 6),
            .RX_DELAY (RXD)
        ) u_dut (
            .clk     (clk),
            .reset   (reset),
            .start   (start_d[g]),
            .mode_in (mode_d[g]),
            .msg     (msg_d[g]),
            .key     (key_d[g][GKB-1:0]),
            .SOMI    (somi),
            .SIMO    (simo_v[g]),
            .mode    (mode_v[g]),
            .result  (result_v[g]),
            .busy    (busy_v[g]),
            .done    (done_v[g])
        );

        // Slave model: record 128+key bits from SIMO, then answer RXD edges later.
        initial begin : p_slave
            logic [383:0] cap;
            logic [255:0] kc;
            logic [127:0] rsp;
            logic         idle_or;
            bit           ok;
            txn_t         t;
            somi = 1'b0;
            forever begin
                @(negedge clk);
                if (busy_v[g] === 1'b1 && !reset) begin
                    acc_cyc = cyc;
                    ok      = 1'b1;
                    cap     = '0;
                    idle_or = 1'b0;
                    rsp     = '0;
                    chk("result_hold", {128'h0, result_v[g]}, {128'h0, r_last});
                    for (int i = 0; i < 128 + GKB; i++) begin
                        if (i > 0) @(negedge clk);
                        if (reset) begin
                            ok = 1'b0;
                            break;
                        end
                        cap[i] = simo_v[g];
                    end
                    if (ok) begin
                        kc = '0;
                        kc[GKB-1:0] = cap[128 +: GKB];
                        if (q_size(g) == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL tx_unexpected: transfer seen with no queued transaction");
                        end else begin
                            t = q_front(g);
                            chk("tx_msg", {128'h0, cap[127:0]}, {128'h0, t.m});
                            chk("tx_key", kc, t.k);
                        end
                        rsp = ref_fn(cap[127:0], kc, mode_v[g]);
                        for (int j = 1; j <= RXD; j++) begin
                            @(negedge clk);
                            if (reset) begin
                                ok = 1'b0;
                                break;
                            end
                            idle_or = idle_or | simo_v[g];
                        end
                    end
                    if (ok) begin
                        chk("tx_idle", {255'h0, idle_or}, 256'h0);
                        somi = rsp[0];
                        for (int j = 1; j < 128; j++) begin
                            @(negedge clk);
                            if (reset) break;
                            somi = rsp[j];
                        end
                    end
                    for (int j = 0; j < 8 && busy_v[g] === 1'b1 && !reset; j++) @(negedge clk);
                    somi = 1'b0;
                end
            end
        end

        always @(negedge clk) begin : p_monitor
            txn_t t;
            if (reset) begin
                r_last = '0;
                chk_w  = 1'b0;
            end else begin
                if (chk_w) begin
                    chk("done_width", {255'h0, done_v[g]}, 256'h0);
                    chk_w = 1'b0;
                end
                if (done_v[g] === 1'b1) begin
                    chk_w = 1'b1;
                    if (q_size(g) == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL extra_done: done on instance %0d with empty scoreboard", g);
                    end else begin
                        t = q_pop(g);
                        chk("result", {128'h0, result_v[g]}, {128'h0, t.exp});
                        chk("mode_hold", {255'h0, mode_v[g]}, {255'h0, t.md});
                        chk("busy_clear", {255'h0, busy_v[g]}, 256'h0);
                        chk("latency", 256'(cyc - acc_cyc), 256'(256 + GKB + RXD));
                    end
                    r_last = result_v[g];
                end
            end
        end
    end

    task automatic issue(input int idx, input logic [127:0] m, input logic [255:0] k,
                         input logic md);
        txn_t t;
        logic [255:0] kk;
        kk    = (idx == 0) ? {128'h0, k[127:0]} : k;
        t.m   = m;
        t.k   = kk;
        t.md  = md;
        t.exp = ref_fn(m, kk, md);
        q_push(idx, t);
        msg_d[idx]   = m;
        key_d[idx]   = kk;
        mode_d[idx]  = md;
        start_d[idx] = 1'b1;
        @(negedge clk);
        start_d[idx] = 1'b0;
        chk("busy_accept", {255'h0, busy_v[idx]}, 256'h1);
        chk("mode_latch", {255'h0, mode_v[idx]}, {255'h0, md});
        msg_d[idx]  = rnd128();
        key_d[idx]  = {rnd128(), rnd128()};
        mode_d[idx] = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input int idx);
        int n;
        n = 0;
        while (done_v[idx] !== 1'b1 && n < 1500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1500) chk("done_timeout", {255'h0, done_v[idx]}, 256'h1);
    endtask

    task automatic wait_idle(input int idx);
        int n;
        n = 0;
        while ((busy_v[idx] !== 1'b0 || done_v[idx] !== 1'b0) && n < 1500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1500) chk("idle_timeout", {255'h0, busy_v[idx]}, 256'h0);
        @(negedge clk);
    endtask

    initial begin : p_watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : p_main
        logic [127:0] m;
        int           a;
        int           d;
        int           n;
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        reset   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_d[i] = 1'b0;
            mode_d[i]  = 1'b0;
            msg_d[i]   = '0;
            key_d[i]   = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_simo", {255'h0, simo_v[0]}, 256'h0);
        chk("rst_busy", {255'h0, busy_v[0]}, 256'h0);
        chk("rst_done", {255'h0, done_v[0]}, 256'h0);
        chk("rst_result", {128'h0, result_v[0]}, 256'h0);
        reset = 1'b0;
        @(negedge clk);

        // FIPS-197 encrypt vector
        issue(0, FIPS_PT, {128'h0, FIPS_KEY}, 1'b0);
        wait_done(0);
        chk("fips_result", {128'h0, result_v[0]}, {128'h0, FIPS_CT});
        @(negedge clk);
        chk("fips_busy_after", {255'h0, busy_v[0]}, 256'h0);
        wait_idle(0);

        // Bit order: zero key, slave replies with ~msg
        m = rnd128();
        issue(0, m, 256'h0, 1'b0);
        wait_done(0);
        chk("bitorder_result", {128'h0, result_v[0]}, {128'h0, ~m});
        wait_idle(0);

        // start pulses during SEND_KEY and WAIT are ignored
        m = rnd128();
        issue(0, m, 256'h0, 1'b0);
        repeat (140) @(negedge clk);
        start_d[0] = 1'b1;
        @(negedge clk);
        start_d[0] = 1'b0;
        repeat (119) @(negedge clk);
        start_d[0] = 1'b1;
        @(negedge clk);
        start_d[0] = 1'b0;
        wait_done(0);
        chk("ignore_start_result", {128'h0, result_v[0]}, {128'h0, ~m});
        wait_idle(0);

        // Back-to-back with start held through the done cycle
        issue(0, rnd128(), {rnd128(), rnd128()}, 1'b0);
        wait_done(0);
        d = cyc;
        m = rnd128();
        begin
            txn_t t;
            t.m   = m;
            t.k   = {128'h0, 128'h0123456789abcdef0011223344556677};
            t.md  = 1'b1;
            t.exp = ref_fn(t.m, t.k, t.md);
            q_push(0, t);
            msg_d[0]   = t.m;
            key_d[0]   = t.k;
            mode_d[0]  = 1'b1;
            start_d[0] = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy_v[0] !== 1'b1 && n < 10);
        start_d[0] = 1'b0;
        chk("b2b_gap", 256'(cyc - d), 256'd2);
        chk("b2b_mode", {255'h0, mode_v[0]}, 256'h1);
        wait_done(0);
        chk("b2b_result", {128'h0, result_v[0]},
            {128'h0, ~m ^ 128'h0123456789abcdef0011223344556677 ^ {128{1'b1}}});
        wait_idle(0);

        // Reset at message bit 60 with mode=1 and a non-zero prior result
        m = rnd128();
        m[60] = 1'b1;
        issue(0, m, {rnd128(), rnd128()}, 1'b1);
        repeat (60) @(negedge clk);
        chk("pre_reset_simo", {255'h0, simo_v[0]}, 256'h1);
        #1 reset = 1'b1;
        #1;
        chk("arst_simo", {255'h0, simo_v[0]}, 256'h0);
        chk("arst_busy", {255'h0, busy_v[0]}, 256'h0);
        chk("arst_done", {255'h0, done_v[0]}, 256'h0);
        chk("arst_result", {128'h0, result_v[0]}, 256'h0);
        chk("arst_mode", {255'h0, mode_v[0]}, 256'h0);
        q0.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        m = rnd128();
        issue(0, m, 256'h0, 1'b0);
        wait_done(0);
        chk("post_reset_result", {128'h0, result_v[0]}, {128'h0, ~m});
        wait_idle(0);

        // NK=8 key on SIMO and latency
        m = rnd128();
        issue(1, m, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 1'b0);
        a = cyc;
        wait_done(1);
        chk("nk8_latency", 256'(cyc - a), 256'(128 + 256 + RXD + 128));
        wait_idle(1);

        // Randomized traffic on both instances
        for (int i = 0; i < 6; i++) begin
            int idx;
            idx = i % 2;
            issue(idx, rnd128(), {rnd128(), rnd128()}, 1'($urandom_range(0, 1)));
            wait_done(idx);
            wait_idle(idx);
        end

        repeat (4) @(negedge clk);
        chk("sb_empty0", 256'(q0.size()), 256'h0);
        chk("sb_empty1", 256'(q1.size()), 256'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
